// File: rtl/add_seq_ctrl.sv
// Multi-word adder sequencer: streams WORDS 16-bit slices through an external adder, LSW first.
// Optional subtraction is compiled in with ADD_SEQ_SUB_EN.
module add_seq_ctrl #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [16*WORDS-1:0]  a,
  input  logic [16*WORDS-1:0]  b,
  input  logic                 cin,
  input  logic                 sub,
  output logic [15:0]          add_x,
  output logic [15:0]          add_y,
  output logic                 add_cin,
  input  logic [15:0]          add_s,
  input  logic                 add_cout,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [16*WORDS-1:0]  sum,
  output logic                 cout,
  output logic                 ovf,
  output logic [1:0]           o_dbg_state,
  output logic                 o_dbg_sub
);

  // in_valid/in_ready: request accepted on an edge where both are 1 (IDLE only);
  // out_valid/out_ready: result consumed on an edge where both are 1 (DONE only).
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

  localparam int          IW   = 3;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_t                r_state;
  logic [IW-1:0]         r_idx;
  logic                  r_carry;
  logic                  r_sub;
  logic [16*WORDS-1:0]   r_a;
  logic [16*WORDS-1:0]   r_b;
  logic [16*WORDS-1:0]   r_sum;
  logic                  r_cout;
  logic                  r_ovf;

  logic                  w_run;
  logic [15:0]           w_aword;
  logic [15:0]           w_bword;
  logic [15:0]           w_yword;

  always_comb begin
    w_aword = '0;
    w_bword = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (r_idx == IW'(w)) begin
        w_aword = r_a[16*w +: 16];
        w_bword = r_b[16*w +: 16];
      end
    end
  end

`ifdef ADD_SEQ_SUB_EN
  assign w_yword = w_bword ^ {16{r_sub}};
`else
  assign w_yword = w_bword;
`endif

  assign w_run       = (r_state == S_RUN);
  assign add_x       = w_run ? w_aword : 16'h0;
  assign add_y       = w_run ? w_yword : 16'h0;
  assign add_cin     = w_run & r_carry;
  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign ovf         = r_ovf;
  assign o_dbg_state = r_state;
  assign o_dbg_sub   = r_sub;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sub   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_sub   <= sub;
            r_idx   <= '0;
`ifdef ADD_SEQ_SUB_EN
            r_carry <= sub ? 1'b1 : cin;
`else
            r_carry <= cin;
`endif
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int w = 0; w < WORDS; w++) begin
            if (r_idx == IW'(w)) r_sum[16*w +: 16] <= add_s;
          end
          r_carry <= add_cout;
          r_idx   <= r_idx + 1'b1;
          // Final word: its msbs are the operand sign bits for overflow.
          if (r_idx == LAST) begin
            r_cout  <= add_cout;
            r_ovf   <= (w_aword[15] == w_yword[15]) && (add_s[15] != w_aword[15]);
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Bench for add_seq_ctrl (WORDS=4): directed table, abort-on-reset sequence and randomized
// operations scored against an arithmetic reference model with an external-adder model.
module tb_add_seq_ctrl;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic [15:0]   add_x;
  logic [15:0]   add_y;
  logic          add_cin;
  logic [15:0]   add_s;
  logic          add_cout;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;
  logic [1:0]    dbg_state;
  logic          dbg_sub;

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entries: {cout, ovf, sum}
  logic [W+1:0] exp_q[$];

  typedef struct {
    string        name;
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    int           hold;
    logic [W-1:0] e_sum;
    logic         e_cout;
    logic         e_ovf;
  } vec_t;

  vec_t vecs[5];

  add_seq_ctrl #(.WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin),
    .add_s(add_s), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf),
    .o_dbg_state(dbg_state), .o_dbg_sub(dbg_sub)
  );

  // External combinational 16-bit adder
  assign {add_cout, add_s} = {1'b0, add_x} + {1'b0, add_y} + 17'(add_cin);

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W+1:0] ref_model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                             input logic mcin, input logic msub);
    logic [W:0]   full;
    logic [W-1:0] bp;
    logic         c;
    bp = mb;
    c  = mcin;
`ifdef ADD_SEQ_SUB_EN
    if (msub) begin
      bp = ~mb;
      c  = 1'b1;
    end
`else
    if (msub) c = mcin;
`endif
    full = {1'b0, ma} + {1'b0, bp} + (W+1)'(c);
    return {full[W], (ma[W-1] == bp[W-1]) && (full[W-1] != ma[W-1]), full[W-1:0]};
  endfunction

  // ---------------- driver ----------------
  // Called at a negedge with the DUT idle; runs one full operation.
  task automatic run_op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tcin, input logic tsub, input int hold);
    int           lat;
    logic [W+1:0] e;
    logic [W-1:0] wa;
    wa = ta;
    chk({name, ".in_ready_idle"}, W'(in_ready), W'(1));
    a = ta; b = tb_v; cin = tcin; sub = tsub; in_valid = 1'b1;
    exp_q.push_back(ref_model(ta, tb_v, tcin, tsub));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom, $urandom, $urandom};
    b = {$urandom, $urandom, $urandom, $urandom};
    cin = 1'($urandom); sub = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (lat < WORDS) chk({name, ".add_x_word"}, W'(add_x), W'(wa[16*lat +: 16]));
      tick();
      lat++;
    end
    chk({name, ".latency"}, W'(lat), W'(WORDS));
    if (!out_valid) begin
      $display("FAIL %s.timeout: out_valid never rose", name);
      n_checks++;
      void'(exp_q.pop_front());
      return;
    end
    e = exp_q.pop_front();
    chk({name, ".sum"},  sum,       e[W-1:0]);
    chk({name, ".cout"}, W'(cout),  W'(e[W+1]));
    chk({name, ".ovf"},  W'(ovf),   W'(e[W]));
    chk({name, ".add_x_done"}, W'(add_x), W'(0));
    for (int h = 0; h < hold; h++) begin
      out_ready = 1'b0;
      in_valid  = 1'b1;
      tick();
      chk({name, ".hold_valid"}, W'(out_valid), W'(1));
      chk({name, ".hold_ready"}, W'(in_ready),  W'(0));
      chk({name, ".hold_sum"},   sum,           e[W-1:0]);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, ".release_valid"}, W'(out_valid), W'(0));
    chk({name, ".release_ready"}, W'(in_ready),  W'(1));
  endtask

  // ---------------- main ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    vecs[0] = '{"carry_chain", 64'h0000_0000_0000_FFFF, 64'h1, 1'b0, 1'b0, 0,
                64'h0000_0000_0001_0000, 1'b0, 1'b0};
    vecs[1] = '{"all_ones_cin", 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 1,
                64'h0, 1'b1, 1'b0};
    vecs[2] = '{"signed_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 0,
                64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{"stall3", 64'h1234_5678_9ABC_DEF0, 64'h1111_2222_3333_4444, 1'b0, 1'b0, 3,
                64'h2345_789A_CDF0_2334, 1'b0, 1'b0};
`ifdef ADD_SEQ_SUB_EN
    vecs[4] = '{"sub_0_minus_1", 64'h0, 64'h1, 1'b0, 1'b1, 0,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
`else
    vecs[4] = '{"sub_ignored", 64'h0, 64'h1, 1'b0, 1'b1, 0,
                64'h1, 1'b0, 1'b0};
`endif

    tick(); tick();
    rst = 1'b0;
    chk("reset.in_ready",  W'(in_ready),  W'(1));
    chk("reset.out_valid", W'(out_valid), W'(0));
    chk("reset.sum",       sum,           W'(0));
    chk("reset.cout_ovf",  W'({cout, ovf}), W'(0));
    chk("reset.add_bus",   W'({add_x, add_y, add_cin}), W'(0));

    // Directed table: constants for expected values, also cross-checked against the model
    foreach (vecs[i]) begin
      logic [W+1:0] m;
      m = ref_model(vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub);
      chk({vecs[i].name, ".model"}, m[W-1:0], vecs[i].e_sum);
      run_op(vecs[i].name, vecs[i].va, vecs[i].vb, vecs[i].vcin, vecs[i].vsub, vecs[i].hold);
      chk({vecs[i].name, ".tbl_sum"}, sum, vecs[i].e_sum);
      chk({vecs[i].name, ".tbl_flags"}, W'({cout, ovf}), W'({vecs[i].e_cout, vecs[i].e_ovf}));
    end

    // Abort in RUN at index 2
    a = 64'hAAAA_BBBB_CCCC_DDDD; b = 64'h1111_1111_1111_1111; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    chk("abort.add_x_idx2", W'(add_x), W'(16'hBBBB));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.in_ready", W'(in_ready), W'(1));
    chk("abort.sum",      sum,          W'(0));
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        if (out_valid) seen++;
        tick();
      end
      chk("abort.no_out_valid", W'(seen), W'(0));
    end
    run_op("after_abort", 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 1'b0, 0);
    chk("after_abort.sum", sum, 64'h0);

    // Randomized operations
    for (int r = 0; r < 25; r++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = {W{1'b1}};
      if ($urandom_range(0, 3) == 0) rb = {1'b0, {(W-1){1'b1}}};
      run_op($sformatf("rand%0d", r), ra, rb, 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
